// File: rtl/fifo_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module : fifo_pkg                                                     |
// | Brief  : Shared pointer widths and Gray/binary helpers for async FIFO |
// | Rev    : 1.0  initial release                                         |
// +-----------------------------------------------------------------------+
package fifo_pkg;

  localparam int DEF_ADDR_SIZE = 4;
  localparam int PTR_W         = DEF_ADDR_SIZE + 1;
  localparam int MAX_PTR_W     = 32;

  typedef logic [MAX_PTR_W-1:0] ptr_max_t;

  function automatic ptr_max_t bin2gray(input ptr_max_t b);
    return b ^ (b >> 1);
  endfunction

  // Zero-extended inputs keep the upper prefix bits zero, so one width serves all pointers.
  function automatic ptr_max_t gray2bin(input ptr_max_t g);
    ptr_max_t b;
    b[MAX_PTR_W-1] = g[MAX_PTR_W-1];
    for (int i = MAX_PTR_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module : sync_2ff                                                     |
// | Brief  : Two-flop clock-domain synchronizer with synchronous reset    |
// | Rev    : 1.0  initial release                                         |
// +-----------------------------------------------------------------------+
module sync_2ff #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q1;

  // Flop-to-flop with nothing in between so the first stage can resolve.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q1 <= '0;
      q    <= '0;
    end else begin
      r_q1 <= d;
      q    <= r_q1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_rptr_empty.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module : fifo_rptr_empty                                              |
// | Brief  : Async FIFO read pointer, empty/almost-empty flags and level  |
// | Rev    : 1.0  initial release                                         |
// +-----------------------------------------------------------------------+
module fifo_rptr_empty
  import fifo_pkg::*;
#(
  parameter int ADDR_SIZE       = PTR_W - 1,
  parameter int ALMOST_EMPTY_TH = 2
) (
  input  logic                 rclk,
  input  logic                 rst,
  input  logic                 rd_en,
  input  logic [ADDR_SIZE:0]   wr_ptr_gray,
  output logic [ADDR_SIZE-1:0] rd_addr,
  output logic [ADDR_SIZE:0]   rd_ptr_gray,
  output logic                 fifo_empty,
  output logic                 almost_empty,
  output logic [ADDR_SIZE:0]   rd_level
);

  localparam int                  c_PTR_W = ADDR_SIZE + 1;
  localparam logic [c_PTR_W-1:0]  c_AE_TH = c_PTR_W'(ALMOST_EMPTY_TH);

  logic [c_PTR_W-1:0] r_rbin;
  logic [c_PTR_W-1:0] w_wq2;
  logic               w_rd_inc;
  logic [c_PTR_W-1:0] w_rbin_next;
  logic [c_PTR_W-1:0] w_rgray_next;
  logic [c_PTR_W-1:0] w_wbin_sync;
  logic [c_PTR_W-1:0] w_level_next;

  sync_2ff #(.W(c_PTR_W)) u_wptr_sync (
    .clk (rclk),
    .rst (rst),
    .d   (wr_ptr_gray),
    .q   (w_wq2)
  );

  always_comb begin
    w_rd_inc     = rd_en & ~fifo_empty;
    w_rbin_next  = r_rbin + {{(c_PTR_W-1){1'b0}}, w_rd_inc};
    w_rgray_next = c_PTR_W'(bin2gray(ptr_max_t'(w_rbin_next)));
    w_wbin_sync  = c_PTR_W'(gray2bin(ptr_max_t'(w_wq2)));
    // Synchronized write pointer lags reality, so this level can only under-report.
    w_level_next = w_wbin_sync - w_rbin_next;
  end

  always_ff @(posedge rclk) begin
    if (rst) begin
      r_rbin       <= '0;
      rd_ptr_gray  <= '0;
      fifo_empty   <= 1'b1;
      almost_empty <= 1'b1;
      rd_level     <= '0;
    end else begin
      r_rbin       <= w_rbin_next;
      rd_ptr_gray  <= w_rgray_next;
      fifo_empty   <= (w_rgray_next == w_wq2);
      almost_empty <= (w_level_next <= c_AE_TH);
      rd_level     <= w_level_next;
    end
  end

  assign rd_addr = r_rbin[ADDR_SIZE-1:0];

endmodule
`default_nettype wire
